// File: rtl/trs_io_pkg.sv
// Shared TRS-IO definitions: printer status bytes, ESP request encodings and
// the printer spool request FSM state type.
package trs_io_pkg;

  localparam logic [7:0] PRINTER_STATUS_READY = 8'h30;
  localparam logic [7:0] PRINTER_STATUS_BUSY  = 8'hf0;

  localparam logic [2:0] esp_idle       = 3'd0;
  localparam logic [2:0] esp_printer_wr = 3'd4;

  typedef enum logic [1:0] {
    SPOOL_IDLE,
    SPOOL_REQ,
    SPOOL_WAIT_DONE
  } spool_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular FIFO with a registered show-ahead head and fill level.
// The head register is 0 whenever the FIFO is empty.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic                     clear,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [LW-1:0]    level_nxt;
  logic             full, empty, do_push, do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  // A pop frees the slot a same-cycle push needs, so full+push+pop is legal.
  assign do_pop  = rd_en && !empty && !clear;
  assign do_push = wr_en && (!full || rd_en) && !clear;
  assign drop    = wr_en && full && !rd_en && !clear;

  always_comb begin
    rd_ptr_nxt = do_pop ? rd_ptr + 1'b1 : rd_ptr;
    level_nxt  = level;
    case ({do_push, do_pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      head_data <= '0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      head_data <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= rd_ptr_nxt;
      level  <= level_nxt;
      // New head may be the byte being written right now (bypass the array).
      if (level_nxt == '0)
        head_data <= '0;
      else if (do_push && (rd_ptr_nxt == wr_ptr))
        head_data <= wr_data;
      else
        head_data <= mem[rd_ptr_nxt];
    end
  end

endmodule

// File: rtl/printer_spool.sv
// Z80 printer spool: queues printer port writes, reports BUSY/READY status and
// pulses esp_req to the ESP until it signals esp_done or the wait times out.
module printer_spool
  import trs_io_pkg::*;
#(
  parameter int          DEPTH          = 16,
  parameter int          BUSY_LEVEL     = 16,
  parameter int          REQ_CYCLES     = 50,
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  STATUS_READY   = PRINTER_STATUS_READY,
  parameter logic [7:0]  STATUS_BUSY    = PRINTER_STATUS_BUSY
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_stb,
  input  logic [7:0]              wr_data,
  output logic [7:0]              status,
  input  logic                    pop,
  output logic [7:0]              head_data,
  output logic [$clog2(DEPTH):0]  level,
  input  logic                    flush,
  output logic                    esp_req,
  input  logic                    esp_done,
  output logic                    overflow,
  output logic                    timeout,
  input  logic                    clr_flags
);

  localparam int LW      = $clog2(DEPTH) + 1;
  localparam int CNT_MAX = (REQ_CYCLES > TIMEOUT_CYCLES) ? REQ_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  spool_state_t  state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          req_nxt, timeout_set, drop, done_rise;
  logic [2:0]    done_sync;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_stb),
    .wr_data   (wr_data),
    .rd_en     (pop),
    .clear     (flush),
    .head_data (head_data),
    .level     (level),
    .drop      (drop)
  );

  assign status = (level >= LW'(BUSY_LEVEL)) ? STATUS_BUSY : STATUS_READY;

  // [1:0] synchronise the asynchronous pin, [2] holds the previous sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_sync <= '0;
    else        done_sync <= {done_sync[1:0], esp_done};
  end
  assign done_rise = done_sync[1] & ~done_sync[2];

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    req_nxt     = esp_req;
    timeout_set = 1'b0;
    if (flush) begin
      state_nxt = SPOOL_IDLE;
      cnt_nxt   = '0;
      req_nxt   = 1'b0;
    end else begin
      case (state)
        SPOOL_IDLE: begin
          if (level != '0) begin
            state_nxt = SPOOL_REQ;
            cnt_nxt   = CW'(REQ_CYCLES);
            req_nxt   = 1'b1;
          end
        end
        SPOOL_REQ: begin
          if (cnt == CW'(1)) begin
            state_nxt = SPOOL_WAIT_DONE;
            cnt_nxt   = CW'(TIMEOUT_CYCLES);
            req_nxt   = 1'b0;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        SPOOL_WAIT_DONE: begin
          if (done_rise) begin
            state_nxt = SPOOL_IDLE;
          end else if (cnt == CW'(1)) begin
            state_nxt   = SPOOL_IDLE;
            timeout_set = 1'b1;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        default: begin
          state_nxt = SPOOL_IDLE;
          req_nxt   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SPOOL_IDLE;
      cnt     <= '0;
      esp_req <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      esp_req <= req_nxt;
    end
  end

  // Sticky flags: a set in the same cycle as clr_flags wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      overflow <= drop        | (overflow & ~clr_flags);
      timeout  <= timeout_set | (timeout  & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_printer_spool.sv
// Directed bench for printer_spool: two instances (16-deep and 4-deep) driven
// in one linear sequence, head bytes checked against a queue scoreboard.
module tb_printer_spool;

  localparam int DEPTH_A = 16;
  localparam int DEPTH_B = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       wr_stb_a = 0, pop_a = 0, flush_a = 0, clr_a = 0, esp_done_a = 0;
  logic [7:0] wr_data_a = 0, status_a, head_a;
  logic [4:0] level_a;
  logic       esp_req_a, overflow_a, timeout_a;

  logic       wr_stb_b = 0, pop_b = 0, flush_b = 0, clr_b = 0, esp_done_b = 0;
  logic [7:0] wr_data_b = 0, status_b, head_b;
  logic [2:0] level_b;
  logic       esp_req_b, overflow_b, timeout_b;

  printer_spool #(.DEPTH(DEPTH_A), .BUSY_LEVEL(16), .REQ_CYCLES(50), .TIMEOUT_CYCLES(100)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_stb(wr_stb_a), .wr_data(wr_data_a), .status(status_a),
    .pop(pop_a), .head_data(head_a), .level(level_a), .flush(flush_a), .esp_req(esp_req_a),
    .esp_done(esp_done_a), .overflow(overflow_a), .timeout(timeout_a), .clr_flags(clr_a)
  );

  printer_spool #(.DEPTH(DEPTH_B), .BUSY_LEVEL(3), .REQ_CYCLES(50), .TIMEOUT_CYCLES(100)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_stb(wr_stb_b), .wr_data(wr_data_b), .status(status_b),
    .pop(pop_b), .head_data(head_b), .level(level_b), .flush(flush_b), .esp_req(esp_req_b),
    .esp_done(esp_done_b), .overflow(overflow_b), .timeout(timeout_b), .clr_flags(clr_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  always @(posedge clk) cyc <= cyc + 1;

  // esp_req pulse monitor for instance A
  int   rise_cyc = 0, fall_cyc = 0, n_rises = 0;
  logic req_prev = 1'b0;
  always @(negedge clk) begin
    if (esp_req_a && !req_prev) begin
      rise_cyc <= cyc;
      n_rises  <= n_rises + 1;
    end
    if (!esp_req_a && req_prev) fall_cyc <= cyc;
    req_prev <= esp_req_a;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_a(input logic w, input logic [7:0] d, input logic p, input logic f, input logic c);
    int sz;
    sz = q_a.size();
    if (p && sz > 0 && !f) check("head_a_at_pop", head_a, q_a[0]);
    wr_stb_a = w; wr_data_a = d; pop_a = p; flush_a = f; clr_a = c;
    tick();
    wr_stb_a = 0; pop_a = 0; flush_a = 0; clr_a = 0;
    if (f) q_a.delete();
    else begin
      if (p && sz > 0) void'(q_a.pop_front());
      if (w && (sz < DEPTH_A || p)) q_a.push_back(d);
    end
  endtask

  task automatic step_b(input logic w, input logic [7:0] d, input logic p, input logic f, input logic c);
    int sz;
    sz = q_b.size();
    if (p && sz > 0 && !f) check("head_b_at_pop", head_b, q_b[0]);
    wr_stb_b = w; wr_data_b = d; pop_b = p; flush_b = f; clr_b = c;
    tick();
    wr_stb_b = 0; pop_b = 0; flush_b = 0; clr_b = 0;
    if (f) q_b.delete();
    else begin
      if (p && sz > 0) void'(q_b.pop_front());
      if (w && (sz < DEPTH_B || p)) q_b.push_back(d);
    end
  endtask

  task automatic wait_req_a(input logic v, input int max_cyc, input string tag);
    int n = 0;
    while (esp_req_a !== v && n < max_cyc) begin
      tick();
      n++;
    end
    check(tag, esp_req_a, v);
  endtask

  initial begin
    int first_push_cyc;
    int r0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #12;
    check("rst_level_a", level_a, 0);
    check("rst_head_a", head_a, 8'h00);
    check("rst_status_a", status_a, 8'h30);
    check("rst_req_a", esp_req_a, 0);
    check("rst_ovf_a", overflow_a, 0);
    check("rst_tmo_a", timeout_a, 0);
    check("rst_level_b", level_b, 0);
    check("rst_status_b", status_b, 8'h30);
    check("rst_req_b", esp_req_b, 0);
    check("rst_tmo_b", timeout_b, 0);
    #10 rst_n = 1'b1;
    tick();

    // three pushes, request pulse length and latency
    step_a(1, 8'h41, 0, 0, 0);
    first_push_cyc = cyc;
    step_a(1, 8'h42, 0, 0, 0);
    step_a(1, 8'h43, 0, 0, 0);
    check("level_3", level_a, q_a.size());
    check("status_ready_a", status_a, 8'h30);
    tick();
    check("head_41", head_a, q_a[0]);
    check("req_high", esp_req_a, 1);
    wait_req_a(0, 100, "req_fall");
    tick();
    check("req_len", fall_cyc - rise_cyc, 50);
    check("req_latency_le2", ((rise_cyc - first_push_cyc) <= 2) ? 1 : 0, 1);
    check("req_count_1", n_rises, 1);

    // drain, then esp_done returns the FSM to idle
    step_a(0, 0, 1, 0, 0);
    step_a(0, 0, 1, 0, 0);
    step_a(0, 0, 1, 0, 0);
    check("level_0", level_a, 0);
    check("head_empty", head_a, 8'h00);
    esp_done_a = 1;
    repeat (3) tick();
    esp_done_a = 0;
    repeat (120) tick();
    check("idle_no_req", esp_req_a, 0);
    check("idle_req_count", n_rises, 1);
    check("done_no_timeout", timeout_a, 0);

    // small FIFO: busy threshold, overflow, full push+pop, flags
    step_b(1, 8'h10, 0, 0, 0);
    step_b(1, 8'h11, 0, 0, 0);
    step_b(1, 8'h12, 0, 0, 0);
    check("b_status_busy", status_b, 8'hf0);
    check("b_level_3", level_b, q_b.size());
    step_b(0, 0, 1, 0, 0);
    check("b_status_ready", status_b, 8'h30);
    step_b(1, 8'h13, 0, 0, 0);
    step_b(1, 8'h14, 0, 0, 0);
    check("b_level_full", level_b, 4);
    step_b(1, 8'h15, 0, 0, 0);
    check("b_overflow_set", overflow_b, 1);
    check("b_level_after_drop", level_b, q_b.size());
    step_b(0, 0, 0, 0, 1);
    check("b_overflow_clr", overflow_b, 0);
    step_b(1, 8'h16, 1, 0, 0);
    check("b_full_pushpop_level", level_b, 4);
    check("b_full_pushpop_ovf", overflow_b, 0);
    step_b(1, 8'h17, 0, 0, 1);
    check("b_set_beats_clr", overflow_b, 1);
    step_b(0, 0, 0, 1, 0);
    check("b_flush_level", level_b, 0);
    check("b_flush_head", head_b, 8'h00);
    check("b_flush_keeps_ovf", overflow_b, 1);
    step_b(0, 0, 1, 0, 0);
    check("b_pop_empty", level_b, 0);
    step_b(1, 8'h21, 1, 0, 0);
    check("b_empty_pushpop", level_b, 1);
    check("b_head_21", head_b, q_b[0]);
    step_b(0, 0, 1, 0, 0);
    check("b_drained", level_b, 0);

    // no esp_done: timeout, retry pulse, clear
    step_a(1, 8'h55, 0, 0, 0);
    wait_req_a(1, 10, "tmo_req_rise");
    wait_req_a(0, 60, "tmo_req_fall");
    repeat (99) tick();
    check("tmo_not_yet", timeout_a, 0);
    tick();
    check("tmo_set", timeout_a, 1);
    tick();
    check("retry_req", esp_req_a, 1);
    tick();
    check("retry_count", n_rises, 3);
    step_a(0, 0, 0, 0, 1);
    check("tmo_cleared", timeout_a, 0);

    // flush during a request with five bytes queued
    step_a(1, 8'h61, 0, 0, 0);
    step_a(1, 8'h62, 0, 0, 0);
    step_a(1, 8'h63, 0, 0, 0);
    step_a(1, 8'h64, 0, 0, 0);
    check("pre_flush_level", level_a, 5);
    check("pre_flush_req", esp_req_a, 1);
    step_a(0, 0, 0, 1, 0);
    check("flush_req", esp_req_a, 0);
    check("flush_level", level_a, 0);
    check("flush_head", head_a, 8'h00);
    check("flush_ovf_kept", overflow_a, 0);
    tick();
    check("flush_stays_idle", esp_req_a, 0);

    // asynchronous reset in the middle of a request
    step_a(1, 8'h77, 0, 0, 0);
    wait_req_a(1, 10, "arst_req_rise");
    #3 rst_n = 1'b0;
    #1;
    q_a.delete();
    check("arst_req", esp_req_a, 0);
    check("arst_level", level_a, 0);
    check("arst_head", head_a, 8'h00);
    #2 rst_n = 1'b1;
    tick();
    r0 = n_rises;
    repeat (10) tick();
    check("arst_idle_req", esp_req_a, 0);
    check("arst_idle_level", level_a, 0);
    check("arst_no_new_req", n_rises, r0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
